// File: rtl/uart_frame_parser.sv
// Frame parser behind a UART receiver: SYNC, LEN, payload, CHK (XOR of LEN and payload).
// The payload is buffered and streamed out on valid/ready only after the checksum matches.
module uart_frame_parser #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_data,
  input  logic       i_dv,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_last,
  output logic       o_frame_ok,
  output logic       o_frame_err,
  output logic       o_overrun
);
  localparam int            AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int            GW        = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [GW-1:0] GAP_LIMIT = GW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN} state_t;

  state_t        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    chk_q, chk_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic          ovr_q, ovr_d;
  logic          wr_en;
  logic [7:0]    idx_nx;
  logic [7:0]    len_m1;
  logic [7:0]    pbuf_q [0:(2**AW)-1];

  assign idx_nx = idx_q + 8'd1;
  assign len_m1 = len_q - 8'd1;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    chk_d   = chk_q;
    gap_d   = '0;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    ovr_d   = 1'b0;
    wr_en   = 1'b0;

    // Inter-byte watchdog; a byte arriving on the limit cycle wins over the timeout.
    if ((state_q == S_LEN || state_q == S_PAYLOAD || state_q == S_CHK) && !i_dv) begin
      if (gap_q == GAP_LIMIT) begin
        err_d   = 1'b1;
        state_d = S_HUNT;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end

    case (state_q)
      S_HUNT: begin
        if (i_dv && i_data == SYNC_BYTE) state_d = S_LEN;
      end
      S_LEN: begin
        if (i_dv) begin
          if (i_data != 8'd0 && i_data <= MAX_LEN_B) begin
            len_d   = i_data;
            chk_d   = i_data;
            idx_d   = 8'd0;
            state_d = S_PAYLOAD;
          end else begin
            err_d   = 1'b1;
            state_d = S_HUNT;
          end
        end
      end
      S_PAYLOAD: begin
        if (i_dv) begin
          wr_en = 1'b1;
          chk_d = chk_q ^ i_data;
          idx_d = idx_nx;
          if (idx_q == len_m1) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (i_dv) begin
          if (i_data == chk_q) begin
            ok_d    = 1'b1;
            idx_d   = 8'd0;
            valid_d = 1'b1;
            data_d  = pbuf_q[0];
            last_d  = (len_q == 8'd1);
            state_d = S_DRAIN;
          end else begin
            err_d   = 1'b1;
            state_d = S_HUNT;
          end
        end
      end
      S_DRAIN: begin
        ovr_d = i_dv;
        if (valid_q && i_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            idx_d   = 8'd0;
            state_d = S_HUNT;
          end else begin
            idx_d  = idx_nx;
            data_d = pbuf_q[idx_nx[AW-1:0]];
            last_d = (idx_nx == len_m1);
          end
        end
      end
      default: state_d = S_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HUNT;
      len_q   <= 8'd0;
      idx_q   <= 8'd0;
      chk_q   <= 8'd0;
      gap_q   <= '0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      chk_q   <= chk_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) pbuf_q[idx_q[AW-1:0]] <= i_data;
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_last      = last_q;
  assign o_frame_ok  = ok_q;
  assign o_frame_err = err_q;
  assign o_overrun   = ovr_q;
endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: queue-based frame model checked every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_uart_frame_parser;
  localparam int         MAX_LEN = 16;
  localparam int         TO      = 40;
  localparam logic [7:0] SYNC    = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i_data = 8'd0;
  logic       i_dv = 1'b0;
  logic       i_ready = 1'b1;
  logic [7:0] o_data;
  logic       o_valid, o_last, o_frame_ok, o_frame_err, o_overrun;

  uart_frame_parser #(.SYNC_BYTE(SYNC), .MAX_LEN(MAX_LEN), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_dv(i_dv),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last),
    .o_frame_ok(o_frame_ok), .o_frame_err(o_frame_err), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ready_mode = 1;  // 0 low, 1 high, 2 random
  int ok_cnt = 0, err_cnt = 0, ovr_cnt = 0;
  logic [7:0] beats[$];

  task automatic tally(input string name, input logic bad, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask
  task automatic chk1(input string name, input logic act, input logic req);
    tally(name, act !== req, {31'd0, act}, {31'd0, req});
  endtask
  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] req);
    tally(name, act !== req, {24'd0, act}, {24'd0, req});
  endtask
  task automatic chkn(input string name, input int act, input int req);
    tally(name, act != req, act, req);
  endtask

  // Reference model: a frame is just the list of bytes collected since SYNC.
  logic [7:0] frm[$];
  logic [7:0] outq[$];
  int         idle = 0;
  logic       exp_valid = 1'b0, exp_last = 1'b0, exp_ok = 1'b0, exp_err = 1'b0, exp_ovr = 1'b0;
  logic [7:0] exp_data = 8'd0;

  always @(posedge clk) begin
    logic [7:0] x;
    int n;
    if (o_valid && i_ready && !rst) beats.push_back(o_data);
    exp_ok = 1'b0; exp_err = 1'b0; exp_ovr = 1'b0;
    if (rst) begin
      frm.delete(); outq.delete(); idle = 0;
    end else if (outq.size() > 0) begin
      if (i_dv) exp_ovr = 1'b1;
      if (i_ready) void'(outq.pop_front());
    end else if (frm.size() == 0) begin
      if (i_dv && i_data == SYNC) begin frm.push_back(i_data); idle = 0; end
    end else if (i_dv) begin
      idle = 0;
      frm.push_back(i_data);
      n = frm.size();
      if (n == 2 && (frm[1] == 8'd0 || int'(frm[1]) > MAX_LEN)) begin
        exp_err = 1'b1; frm.delete();
      end else if (n > 2 && n == int'(frm[1]) + 3) begin
        x = 8'd0;
        for (int i = 1; i < n - 1; i++) x = x ^ frm[i];
        if (x == frm[n-1]) begin
          exp_ok = 1'b1;
          for (int i = 2; i < n - 1; i++) outq.push_back(frm[i]);
        end else exp_err = 1'b1;
        frm.delete();
      end
    end else begin
      idle++;
      if (idle == TO) begin exp_err = 1'b1; frm.delete(); end
    end
    exp_valid = (outq.size() > 0);
    if (exp_valid) begin exp_data = outq[0]; exp_last = (outq.size() == 1); end
  end

  always @(negedge clk) begin
    chk1("valid", o_valid, exp_valid);
    chk1("frame_ok", o_frame_ok, exp_ok);
    chk1("frame_err", o_frame_err, exp_err);
    chk1("overrun", o_overrun, exp_ovr);
    if (exp_valid) begin
      chk8("data", o_data, exp_data);
      chk1("last", o_last, exp_last);
    end
    if (o_frame_ok) ok_cnt++;
    if (o_frame_err) err_cnt++;
    if (o_overrun) ovr_cnt++;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (ready_mode == 0) i_ready = 1'b0;
      else if (ready_mode == 1) i_ready = 1'b1;
      else i_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  // Called at a negedge; leaves i_dv high for exactly one clock edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    i_dv = 1'b1; i_data = b;
    @(negedge clk);
    i_dv = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_good;
    send_byte(8'hA5, 0); send_byte(8'h03, 0); send_byte(8'h11, 0);
    send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h03, 0);
  endtask

  task automatic expect_beats(input string name, input int start, input int n, input logic [23:0] e);
    chkn({name, "_count"}, beats.size() - start, n);
    for (int i = 0; i < n && start + i < beats.size(); i++)
      chk8({name, "_beat"}, beats[start + i], e[23 - 8*i -: 8]);
  endtask

  initial begin
    int b0, ok0, err0, ovr0, kind, len, gap, cut;
    logic [7:0] c, b;
    repeat (3) @(negedge clk);
    chk1("rst_valid", o_valid, 1'b0); chk8("rst_data", o_data, 8'h00);
    chk1("rst_last", o_last, 1'b0);   chk1("rst_ok", o_frame_ok, 1'b0);
    chk1("rst_err", o_frame_err, 1'b0); chk1("rst_ovr", o_overrun, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    b0 = beats.size(); ok0 = ok_cnt;
    send_good();
    chk1("t1_first_valid", o_valid, 1'b1);
    chk8("t1_first_data", o_data, 8'h11);
    repeat (5) @(negedge clk);
    chkn("t1_ok", ok_cnt - ok0, 1);
    expect_beats("t1", b0, 3, 24'h112233);

    b0 = beats.size(); err0 = err_cnt;
    send_byte(8'hA5, 0); send_byte(8'h03, 0); send_byte(8'h11, 0);
    send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h04, 2);
    chkn("t2_err", err_cnt - err0, 1);
    chkn("t2_no_beats", beats.size() - b0, 0);
    send_good(); repeat (5) @(negedge clk);
    expect_beats("t2_good", b0, 3, 24'h112233);

    err0 = err_cnt;
    send_byte(8'hA5, 0); send_byte(8'h00, 1);
    send_byte(8'hA5, 0); send_byte(8'h11, 2);
    chkn("t3_len_err", err_cnt - err0, 2);

    err0 = err_cnt; b0 = beats.size();
    send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h11, 0);
    repeat (TO + 2) @(negedge clk);
    chkn("t4_timeout_err", err_cnt - err0, 1);
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h7E, 0); send_byte(8'h7F, 0);
    chk1("t4_last", o_last, 1'b1);
    repeat (3) @(negedge clk);
    expect_beats("t4", b0, 1, 24'h7E0000);

    b0 = beats.size(); ovr0 = ovr_cnt;
    ready_mode = 0; @(negedge clk);
    send_good();
    repeat (5) @(negedge clk);
    chk1("t5_hold_valid", o_valid, 1'b1); chk8("t5_hold_data", o_data, 8'h11);
    send_byte(8'h55, 14);
    chk8("t5_still_data", o_data, 8'h11);
    chkn("t5_overrun", ovr_cnt - ovr0, 1);
    ready_mode = 1; repeat (6) @(negedge clk);
    expect_beats("t5", b0, 3, 24'h112233);

    b0 = beats.size();
    send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'hA5, 0);
    send_byte(8'h01, 0); send_byte(8'hA5, 0); send_byte(8'hA4, 3);
    expect_beats("t6_garbage", b0, 1, 24'hA50000);

    ok0 = ok_cnt; err0 = err_cnt; ovr0 = ovr_cnt; b0 = beats.size();
    send_byte(8'hA5, 0); send_byte(8'h03, 0); send_byte(8'h11, 0);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk1("t6_rst_valid", o_valid, 1'b0); chk8("t6_rst_data", o_data, 8'h00);
    chk1("t6_rst_last", o_last, 1'b0);
    repeat (TO + 5) @(negedge clk);
    chkn("t6_no_pulses", (ok_cnt - ok0) + (err_cnt - err0) + (ovr_cnt - ovr0), 0);
    send_good(); repeat (5) @(negedge clk);
    expect_beats("t6_after_rst", b0, 3, 24'h112233);

    for (int f = 0; f < 60; f++) begin
      kind = $urandom_range(0, 6);
      len  = $urandom_range(1, MAX_LEN);
      gap  = $urandom_range(0, 2);
      ready_mode = $urandom_range(1, 2);
      if (kind <= 3) begin
        send_byte(SYNC, gap); send_byte(8'(len), gap);
        c = 8'(len);
        for (int i = 0; i < len; i++) begin
          b = 8'($urandom); c = c ^ b; send_byte(b, $urandom_range(0, 2));
        end
        if (kind == 3) c = c ^ 8'($urandom_range(1, 255));
        send_byte(c, gap);
      end else if (kind == 4) begin
        send_byte(SYNC, gap);
        send_byte(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255)), gap);
      end else if (kind == 5) begin
        send_byte(SYNC, gap); send_byte(8'(len), gap);
        cut = $urandom_range(0, len);
        for (int i = 0; i < cut; i++) send_byte(8'($urandom), gap);
        repeat (TO + 2) @(negedge clk);
      end else begin
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), gap);
        repeat (TO + 2) @(negedge clk);
      end
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end

    ready_mode = 1;
    for (int i = 0; i < 200 && (o_valid || frm.size() > 0); i++) @(negedge clk);
    chk1("final_idle", o_valid, 1'b0);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
